// File: rtl/sqrt_prescale.sv
// sqrt_prescale: normalises a 20-bit operand to Q2.20 mantissa m in [0.25,1) and emits CORDIC seeds m+0.25 / m-0.25 with shift count k
module sqrt_prescale #(
  parameter logic [21:0] QUARTER = 22'h040000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] a,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [21:0] x0,
  output logic [21:0] y0,
  output logic [21:0] z0,
  output logic [3:0]  k,
  output logic        zero_flag,
  output logic        out_valid,
  input  logic        out_ready
);
  typedef enum logic [1:0] {IDLE, NORM, HOLD} state_t;
  state_t state_q, state_d;
  logic [19:0] a_q, a_d;
  logic [3:0] cnt_q, cnt_d, k_q, k_d;
  logic [21:0] x_q, x_d, y_q, y_d, m;
  logic zf_q, zf_d;
  assign m = {2'b00, a_q};
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    cnt_d = cnt_q;
    k_d = k_q;
    x_d = x_q;
    y_d = y_q;
    zf_d = zf_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d = a;
        cnt_d = 4'd0;
        if (a == 20'd0) begin
          state_d = HOLD;
          zf_d = 1'b1;
          k_d = 4'd0;
        end else state_d = NORM;
      end
      NORM: if (a_q[19:18] == 2'b00) begin
        a_d = {a_q[17:0], 2'b00};
        cnt_d = cnt_q + 4'd1;
      end else begin
        x_d = m + QUARTER;
        y_d = m - QUARTER;
        k_d = cnt_q;
        zf_d = 1'b0;
        state_d = HOLD;
      end
      HOLD: state_d = out_ready ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q <= '0;
      cnt_q <= '0;
      k_q <= '0;
      x_q <= '0;
      y_q <= '0;
      zf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      cnt_q <= cnt_d;
      k_q <= k_d;
      x_q <= x_d;
      y_q <= y_d;
      zf_q <= zf_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == HOLD;
  assign x0 = x_q;
  assign y0 = y_q;
  assign z0 = '0;
  assign k = k_q;
  assign zero_flag = zf_q;
endmodule

// File: tb/tb_sqrt_prescale.sv
// tb_sqrt_prescale: scoreboard bench for sqrt_prescale with directed vectors
module tb_sqrt_prescale;
  logic clk = 1'b0;
  logic reset, in_valid, in_ready, zero_flag, out_valid, out_ready;
  logic [19:0] a;
  logic [21:0] x0, y0, z0;
  logic [3:0] k;
  int checks = 0, errors = 0, cyc = 0, acc = -1;
  bit prev_ov = 1'b0;
  typedef struct packed {
    logic [21:0] x;
    logic [21:0] y;
    logic [3:0]  k;
    logic        zf;
    logic [7:0]  lat;
  } exp_t;
  exp_t sb[$];
  exp_t me;
  logic [21:0] sx, sy;
  logic [3:0] sk;
  logic szf;

  sqrt_prescale dut (
    .clk(clk), .reset(reset), .a(a), .in_valid(in_valid), .in_ready(in_ready),
    .x0(x0), .y0(y0), .z0(z0), .k(k), .zero_flag(zero_flag),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [21:0] x, input logic [21:0] y, input logic [3:0] kk,
                              input logic zf, input logic [7:0] lat);
    exp_t e;
    e.x = x; e.y = y; e.k = kk; e.zf = zf; e.lat = lat;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      prev_ov = 1'b0;
      acc = -1;
    end else begin
      if (in_valid && in_ready) acc = cyc + 1;
      if (out_valid && !prev_ov) begin
        if (sb.size() == 0) chk("unexpected_out_valid", 32'(out_valid), 32'd0);
        else begin
          me = sb.pop_front();
          chk("latency", 32'(cyc - acc + 1), 32'(me.lat));
          chk("k", 32'(k), 32'(me.k));
          chk("zero_flag", 32'(zero_flag), 32'(me.zf));
          chk("z0", 32'(z0), 32'd0);
          if (!me.zf) begin
            chk("x0", 32'(x0), 32'(me.x));
            chk("y0", 32'(y0), 32'(me.y));
          end
          sx = x0; sy = y0; sk = k; szf = zero_flag;
        end
      end else if (out_valid) begin
        chk("hold_x0", 32'(x0), 32'(sx));
        chk("hold_y0", 32'(y0), 32'(sy));
        chk("hold_k", 32'(k), 32'(sk));
        chk("hold_zf", 32'(zero_flag), 32'(szf));
        chk("hold_in_ready", 32'(in_ready), 32'd0);
      end
      prev_ov = out_valid;
    end
  end

  task automatic reset_vals(input string name);
    chk({name, "_x0"}, 32'(x0), 32'd0);
    chk({name, "_y0"}, 32'(y0), 32'd0);
    chk({name, "_z0"}, 32'(z0), 32'd0);
    chk({name, "_k"}, 32'(k), 32'd0);
    chk({name, "_zf"}, 32'(zero_flag), 32'd0);
    chk({name, "_ov_ir"}, 32'({out_valid, in_ready}), 32'b01);
  endtask

  task automatic send(input logic [19:0] av, input exp_t e, input int hold, input bit junk);
    a = av;
    in_valid = 1'b1;
    sb.push_back(e);
    chk("send_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    if (junk) a = 20'($urandom());
    else in_valid = 1'b0;
    for (int i = 0; i < 20 && !out_valid; i++) begin
      @(posedge clk); #1;
      if (junk) a = 20'($urandom());
    end
    if (!out_valid) begin
      chk("out_valid_timeout", 32'd0, 32'd1);
      return;
    end
    repeat (hold) begin
      @(posedge clk); #1;
      if (junk) a = 20'($urandom());
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_after_ready", 32'({out_valid, in_ready}), 32'b01);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; a = '0; out_ready = 1'b0;
    #3 reset = 1'b0;
    #1 reset_vals("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    send(20'hC0000, mk(22'h100000, 22'h080000, 4'd0, 1'b0, 8'd2), 0, 1'b0);
    send(20'h00000, mk(22'h000000, 22'h000000, 4'd0, 1'b1, 8'd1), 2, 1'b0);
    send(20'h00001, mk(22'h080000, 22'h000000, 4'd9, 1'b0, 8'd11), 0, 1'b0);
    send(20'h10000, mk(22'h080000, 22'h000000, 4'd1, 1'b0, 8'd3), 5, 1'b0);
    send(20'h80000, mk(22'h0C0000, 22'h040000, 4'd0, 1'b0, 8'd2), 0, 1'b0);
    send(20'hFFFFF, mk(22'h13FFFF, 22'h0BFFFF, 4'd0, 1'b0, 8'd2), 1, 1'b0);
    send(20'h00800, mk(22'h0C0000, 22'h040000, 4'd4, 1'b0, 8'd6), 0, 1'b0);
    send(20'h04000, mk(22'h080000, 22'h000000, 4'd2, 1'b0, 8'd4), 0, 1'b0);
    a = 20'h00001;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1 reset_vals("abort");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (15) @(posedge clk);
    #1 chk("abort_idle", 32'({out_valid, in_ready}), 32'b01);
    send(20'hC0000, mk(22'h100000, 22'h080000, 4'd0, 1'b0, 8'd2), 0, 1'b0);
    send(20'h00003, mk(22'h100000, 22'h080000, 4'd9, 1'b0, 8'd11), 1, 1'b1);
    send(20'h00002, mk(22'h0C0000, 22'h040000, 4'd9, 1'b0, 8'd11), 0, 1'b1);
    send(20'h30000, mk(22'h100000, 22'h080000, 4'd1, 1'b0, 8'd3), 2, 1'b1);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sqrt_prescale.md
SQRT_PRESCALE -- requirements
Module: sqrt_prescale

Interface
REQ-001 The block SHALL have one parameter: QUARTER, default 22'h040000, the constant 0.25 in Q2.20 added to and subtracted from the mantissa.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; clears all state immediately when low.
REQ-004 a  input  20  unsigned integer operand whose square root is required.
REQ-005 in_valid  input  1  operand a is present.
REQ-006 in_ready  output  1  block can accept an operand this cycle.
REQ-007 x0  output  22  signed Q2.20 CORDIC x seed, m + 0.25.
REQ-008 y0  output  22  signed Q2.20 CORDIC y seed, m - 0.25.
REQ-009 z0  output  22  CORDIC z seed, always 22'h000000.
REQ-010 k  output  4  number of 2-bit left shifts applied during normalisation, range 0..9.
REQ-011 zero_flag  output  1  the operand was zero; x0/y0 are don't-use.
REQ-012 out_valid  output  1  x0, y0, z0, k and zero_flag are valid.
REQ-013 out_ready  input  1  downstream CORDIC pipeline accepts the outputs.

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, NORM, HOLD.
REQ-015 IDLE: in_ready=1, out_valid=0; on in_valid=1 the block SHALL register a and clear the shift counter. It SHALL go to HOLD with zero_flag=1 if a==0, and to NORM otherwise.
REQ-016 NORM: in_ready=0. Each cycle, if the register bits [19:18]==2'b00, the block SHALL shift the register left by 2 and increment the shift counter.
REQ-017 NORM: otherwise the block SHALL load the outputs and go to HOLD.
REQ-018 Output load: m = {2'b00, a_norm}; x0 = m + QUARTER; y0 = m - QUARTER (22-bit two's complement, no saturation); z0 = 0; k = shift count; zero_flag = 0.
REQ-019 The normalised mantissa SHALL satisfy 0.25 <= m < 1.0, so that x0 lies in [0.5, 1.25) and y0 in [0, 0.75).
REQ-020 The outputs SHALL satisfy sqrt(a) = sqrt(m) * 2^(10-k). Downstream uses k to de-normalise.
REQ-021 HOLD: out_valid=1 and in_ready=0. Outputs SHALL stay stable while out_ready=0.
REQ-022 HOLD: when out_ready=1, the block SHALL return to IDLE on the next edge, with out_valid=0. No new operand is accepted in the same cycle.
REQ-023 Latency, counted from the accept edge T: nonzero a with k shifts gives out_valid at T+2+k (maximum T+11). a==0 gives out_valid at T+1.
REQ-024 in_valid SHALL be ignored outside IDLE. The operand register SHALL not change while in NORM or HOLD, except for the normalisation shifts.
REQ-025 The shift counter SHALL never exceed 9. Nonzero a always normalises within 9 shifts.

Reset
REQ-026 While reset=0, the block SHALL be in IDLE with x0=y0=z0=22'h000000, k=0, zero_flag=0, out_valid=0 and in_ready=1. This applies regardless of the clock.
REQ-027 Reset asserted during NORM or HOLD SHALL abort the operation. The pending operand SHALL be discarded, and no out_valid pulse SHALL occur after reset is released.

Verification
REQ-028 a=20'hC0000 accepted at T -> out_valid at T+2, k=0, x0=22'h100000, y0=22'h080000, z0=0, zero_flag=0.
REQ-029 a=20'h00001 -> out_valid at T+11, k=9, x0=22'h080000, y0=22'h000000.
REQ-030 a=20'h00000 -> out_valid at T+1, zero_flag=1, k=0.
REQ-031 a=20'h10000 with out_ready=0 for 5 cycles after out_valid -> k=1, x0=22'h080000, y0=22'h000000. Outputs stable and in_ready=0 throughout; IDLE one cycle after out_ready=1.
REQ-032 reset pulsed low during NORM for a=20'h00001 -> all outputs at their reset values immediately. No out_valid afterwards, and a fresh a=20'hC0000 is then processed per REQ-028.
REQ-033 in_valid held high continuously with changing a -> only the operand present in IDLE is captured. Each result matches REQ-018 for that captured operand.
